frame_tx: RTL and testbench

- Framing transmitter. Collects a byte payload over a valid/ready input and emits a framed stream, one byte per cycle, on a plain registered data bus.
- Frame format: SOF, LEN, payload bytes, XOR checksum.
- Downstream sink is a free-running per-cycle capture register with no backpressure, so tx_valid alone qualifies tx_data.

---
 rtl/frame_tx_pkg.sv | 25 ++
 rtl/frame_tx_if.sv | 23 ++
 rtl/frame_tx_buf.sv | 46 ++++
 rtl/frame_tx.sv | 105 ++++++++++
 tb/tb_frame_tx.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_tx_pkg.sv
// Shared types and helpers for the frame transmitter.
// The frame on the wire is: SOF, LEN, payload bytes, XOR checksum.
package frame_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SOF,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_GAP
  } state_t;

  localparam logic [7:0] DEFAULT_SOF = 8'hA5;

  // Wide enough for any supported byte width; callers cast in and out.
  localparam int CSUM_W = 32;

  function automatic logic [CSUM_W-1:0] csum_upd(input logic [CSUM_W-1:0] acc,
                                                 input logic [CSUM_W-1:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/frame_tx_if.sv
// Upstream byte handshake and framed output bus of the frame transmitter.
interface frame_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             busy;
  logic             err_overflow;

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, tx_data, tx_valid, busy, err_overflow
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, tx_data, tx_valid, busy, err_overflow
  );
endinterface

// File: rtl/frame_tx_buf.sv
// Payload buffer: MAX_LEN x WIDTH storage with write/read pointers.
// Storage has no reset; only the pointers are cleared.
module frame_tx_buf #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  localparam int CW     = $clog2(MAX_LEN + 1),
  localparam int AW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             rd_last
);

  logic [WIDTH-1:0] mem [MAX_LEN];
  logic [CW-1:0]    wr_ptr;
  logic [CW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign count   = wr_ptr;
  // The entry being read is the final stored payload byte.
  assign rd_last = ((rd_ptr + CW'(1)) == count);

endmodule

// File: rtl/frame_tx.sv
// Framing transmitter: buffers a payload, then emits SOF, LEN, payload, checksum
// one byte per cycle on registered outputs, followed by a single idle gap cycle.
module frame_tx
  import frame_tx_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               MAX_LEN = 16,
  parameter logic [WIDTH-1:0] SOF     = WIDTH'(DEFAULT_SOF)
) (
  input logic        clk,
  input logic        rst_n,
  frame_tx_if.slave  bus
);

  localparam int CW = $clog2(MAX_LEN + 1);

  state_t           state, state_nxt;
  logic             xfer, close, ovf_close, ovf_flag;
  logic             rd_en, clr, rd_last;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rd_data, csum;
  logic [WIDTH-1:0] tx_data_p1;
  logic             tx_valid_p1, busy_p1, err_p1;

  assign bus.in_ready = rst_n && ((state == S_IDLE) || (state == S_LOAD));
  assign xfer         = bus.in_valid && bus.in_ready;
  // A frame closes on in_last or on the transfer that fills the buffer.
  assign close        = xfer && (bus.in_last || (count == CW'(MAX_LEN - 1)));
  assign ovf_close    = close && !bus.in_last;

  frame_tx_buf #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .wr_en   (xfer),
    .wr_data (bus.in_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .count   (count),
    .rd_last (rd_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    clr       = 1'b0;
    unique case (state)
      S_IDLE, S_LOAD: begin
        if (close)     state_nxt = S_SOF;
        else if (xfer) state_nxt = S_LOAD;
      end
      S_SOF:     state_nxt = S_LEN;
      S_LEN:     state_nxt = S_PAYLOAD;
      S_PAYLOAD: begin
        rd_en = 1'b1;
        if (rd_last) state_nxt = S_CSUM;
      end
      S_CSUM:    state_nxt = S_GAP;
      S_GAP: begin
        clr       = 1'b1;
        state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Stage p1: each state's byte is registered onto the output bus one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum        <= '0;
      ovf_flag    <= 1'b0;
      tx_data_p1  <= '0;
      tx_valid_p1 <= 1'b0;
      busy_p1     <= 1'b0;
      err_p1      <= 1'b0;
    end else begin
      if (clr)       csum <= '0;
      else if (xfer) csum <= WIDTH'(csum_upd(CSUM_W'(csum), CSUM_W'(bus.in_data)));
      if (clr)            ovf_flag <= 1'b0;
      else if (ovf_close) ovf_flag <= 1'b1;
      busy_p1     <= (state != S_IDLE) || xfer;
      err_p1      <= (state == S_SOF) && ovf_flag;
      tx_valid_p1 <= (state == S_SOF) || (state == S_LEN) ||
                     (state == S_PAYLOAD) || (state == S_CSUM);
      case (state)
        S_SOF:     tx_data_p1 <= SOF;
        S_LEN:     tx_data_p1 <= WIDTH'(count);
        S_PAYLOAD: tx_data_p1 <= rd_data;
        S_CSUM:    tx_data_p1 <= WIDTH'(count) ^ csum;
        default:   tx_data_p1 <= '0;
      endcase
    end
  end

  assign bus.tx_data      = tx_data_p1;
  assign bus.tx_valid     = tx_valid_p1;
  assign bus.busy         = busy_p1;
  assign bus.err_overflow = err_p1;

endmodule

// File: tb/tb_frame_tx.sv
// Scoreboard bench for frame_tx: stimulus pushes expected frame bytes built from
// the frame format rules; a negedge monitor pops and compares every output byte.
module tb_frame_tx;

  localparam int         W    = 8;
  localparam int         ML   = 16;
  localparam logic [7:0] SOFV = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_tx_if #(.WIDTH(W)) bus ();

  frame_tx #(.WIDTH(W), .MAX_LEN(ML), .SOF(SOFV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [7:0] d;
    bit         ovf;
    bit         eof;
    int         lead;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] cur[$];
  bit         lead_mode = 1'b0;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Reference model: group bytes into frames, then lay out SOF, LEN, payload, checksum.
  task automatic model_push(input logic [7:0] d, input bit last);
    int         n;
    logic [7:0] x;
    cur.push_back(d);
    if (last || cur.size() == ML) begin
      n = cur.size();
      x = 8'(n);
      exp_q.push_back('{SOFV, !last, 1'b0, lead_mode ? n + 1 : -1});
      exp_q.push_back('{8'(n), 1'b0, 1'b0, -1});
      foreach (cur[i]) begin
        exp_q.push_back('{cur[i], 1'b0, 1'b0, -1});
        x = x ^ cur[i];
      end
      exp_q.push_back('{x, 1'b0, 1'b1, -1});
      cur.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      bus.in_last  = 1'($urandom);
      @(posedge clk); #1;
    end
    model_push(d, last);
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", n);
      bus.in_valid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d bytes still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: checks every output byte, frame contiguity, the gap cycle and spacing.
  bit in_frame = 1'b0;
  bit exp_gap = 1'b0;
  int idle_cnt = 0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      in_frame = 1'b0;
      exp_gap  = 1'b0;
      idle_cnt = 0;
    end else begin
      if (exp_gap) begin
        chk("gap_valid", bus.tx_valid, 0);
        chk("gap_data", bus.tx_data, 0);
        chk("gap_err", bus.err_overflow, 0);
        exp_gap = 1'b0;
      end else if (in_frame) begin
        chk("frame_contig", bus.tx_valid, 1);
      end
      if (bus.tx_valid) begin
        chk("ready_low", bus.in_ready, 0);
        chk("busy_high", bus.busy, 1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h expected no output", bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          if (!in_frame && e.lead >= 0) chk("sof_spacing", idle_cnt, e.lead);
          chk("tx_data", bus.tx_data, e.d);
          chk("err_overflow", bus.err_overflow, e.ovf);
          in_frame = !e.eof;
          exp_gap  = e.eof;
        end
        idle_cnt = 0;
      end else begin
        in_frame = 1'b0;
        idle_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int len;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err_overflow, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", bus.in_ready, 1);

    // Basic three-byte frame.
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    send_byte(8'h33, 1'b1, 0);
    bus.in_valid = 1'b0;
    drain();
    chk("idle_busy", bus.busy, 0);
    chk("idle_ready", bus.in_ready, 1);

    // Single byte: SOF right after the edge following the closing transfer.
    send_byte(8'h5A, 1'b1, 0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("sof_latency_valid", bus.tx_valid, 1);
    chk("sof_latency_data", bus.tx_data, SOFV);
    drain();

    // Seventeen bytes without in_last: forced close at MAX_LEN, then a new frame.
    for (int i = 0; i <= ML; i++) send_byte(8'(i), 1'b0, 0);
    send_byte(8'h77, 1'b1, 0);
    bus.in_valid = 1'b0;
    drain();

    // Random payloads with idle gaps on in_valid.
    for (int f = 0; f < 3; f++) begin
      len = $urandom_range(1, ML);
      for (int i = 0; i < len; i++)
        send_byte(8'($urandom), i == len - 1, $urandom_range(0, 3));
    end
    bus.in_valid = 1'b0;
    drain();

    // Reset during payload output of a four-byte frame.
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), i == 3, 0);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.tx_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_test_sof_seen", bus.tx_valid, 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    cur.delete();
    #1;
    chk("midrst_tx_valid", bus.tx_valid, 0);
    chk("midrst_tx_data", bus.tx_data, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_tx_valid", bus.tx_valid, 0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), i == 2, 0);
    bus.in_valid = 1'b0;
    drain();

    // Back-to-back frames with in_valid held high, some longer than MAX_LEN.
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, ML + 4);
      for (int i = 0; i < len; i++) send_byte(8'($urandom), i == len - 1, 0);
      lead_mode = 1'b1;
    end
    lead_mode = 1'b0;
    bus.in_valid = 1'b0;
    drain();

    chk("end_busy", bus.busy, 0);
    chk("end_ready", bus.in_ready, 1);
    chk("end_tx_valid", bus.tx_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
